// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants (640x480@60 defaults) and coordinate type.
// No logic; used by the timing generator, its interface and the bench.
// No flow control: constants and a pure helper function only.
package vga_timing_pkg;
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_CLK_DIV   = 4;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Inclusive range test on a coordinate; used for the sync pulse decode.
  function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable, syncs, blanking, coordinates, frame strobe.
// Pure wiring, no latency.
// No backpressure: the consumer samples on p_tick, the producer never stalls.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   p_tick;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   frame_tick;
  coord_t pixel_x;
  coord_t pixel_y;

  modport master (
    output p_tick, hsync, vsync, video_on, frame_tick, pixel_x, pixel_y
  );

  modport slave (
    input p_tick, hsync, vsync, video_on, frame_tick, pixel_x, pixel_y
  );
endinterface

// File: rtl/pixel_tick_div.sv
// Clock-enable divider: one-clk p_tick pulse every CLK_DIV system clocks.
// First pulse is decoded in the CLK_DIV-th clock after reset release.
// Free running, no backpressure.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // Count 0..CLK_DIV-1 and wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Decoded straight from the register so the pulse is glitch-free and resets low.
  assign p_tick = (div_cnt == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, registered sync/blank decode, frame strobe.
// Syncs/video_on change on the same edge as the coordinates they describe.
// Free running, no backpressure; consumers qualify work with p_tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);
  localparam coord_t H_LAST   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic   p_tick;
  coord_t h_cnt, v_cnt;
  coord_t h_nxt, v_nxt;
  logic   hsync_reg, vsync_reg, video_on_reg, frame_tick_reg;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .p_tick  (p_tick)
  );

  // Next raster position: advance x each pixel, y at end of line, wrap both.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (p_tick) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
      end else begin
        h_nxt = h_cnt + coord_t'(1);
      end
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Decode from the next position so the registered flags line up with the counters.
  // Gated by p_tick so the first pixel after reset stays blanked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_reg      <= 1'b1;
      vsync_reg      <= 1'b1;
      video_on_reg   <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= p_tick && (h_nxt == '0) && (v_nxt == V_VIS);
      if (p_tick) begin
        hsync_reg    <= !in_span(h_nxt, HS_START, HS_END);
        vsync_reg    <= !in_span(v_nxt, VS_START, VS_END);
        video_on_reg <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      end
    end
  end

  assign vga.p_tick     = p_tick;
  assign vga.hsync      = hsync_reg;
  assign vga.vsync      = vsync_reg;
  assign vga.video_on   = video_on_reg;
  assign vga.frame_tick = frame_tick_reg;
  assign vga.pixel_x    = h_cnt;
  assign vga.pixel_y    = v_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for reset/line timing,
// shrunken instance (15x12 raster, CLK_DIV=3) for frame-level behaviour.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if full_if ();
  vga_timing_gen_if small_if ();

  vga_timing_gen dut_full (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (full_if)
  );

  // Small raster: H 8+2+3+2=15, V 6+2+2+2=12, hsync low x 10..12, vsync low y 8..9.
  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(3)
  ) dut_small (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (small_if)
  );

  // Advance on negedges until the small raster sits at (wx,wy), optionally with p_tick.
  task automatic wait_small(input coord_t wx, input coord_t wy, input bit need_tick, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (small_if.pixel_x == wx && small_if.pixel_y == wy && (small_if.p_tick || !need_tick)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    coord_t ex_x;
    int n;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({full_if.p_tick, full_if.hsync, full_if.vsync, full_if.video_on, full_if.frame_tick} !== 5'b01100) begin
      fails++;
      $display("FAIL reset_flags_full: got %b expected 01100",
               {full_if.p_tick, full_if.hsync, full_if.vsync, full_if.video_on, full_if.frame_tick});
    end
    tests++;
    if ({full_if.pixel_x, full_if.pixel_y} !== 20'd0) begin
      fails++;
      $display("FAIL reset_xy_full: got x=%0d y=%0d expected 0,0", full_if.pixel_x, full_if.pixel_y);
    end
    tests++;
    if ({small_if.p_tick, small_if.hsync, small_if.vsync, small_if.video_on, small_if.frame_tick,
         small_if.pixel_x, small_if.pixel_y} !== {5'b01100, 20'd0}) begin
      fails++;
      $display("FAIL reset_small: got flags=%b x=%0d y=%0d expected 01100 0 0",
               {small_if.p_tick, small_if.hsync, small_if.vsync, small_if.video_on, small_if.frame_tick},
               small_if.pixel_x, small_if.pixel_y);
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      ex_x = (i == 4) ? 10'd1 : 10'd0;
      tests++;
      if (full_if.p_tick !== (i == 3)) begin
        fails++;
        $display("FAIL first_tick clk%0d: got %b expected %b", i, full_if.p_tick, (i == 3));
      end
      tests++;
      if (full_if.pixel_x !== ex_x || full_if.video_on !== (i == 4)) begin
        fails++;
        $display("FAIL first_pixel clk%0d: got x=%0d video_on=%b expected x=%0d video_on=%b",
                 i, full_if.pixel_x, full_if.video_on, ex_x, (i == 4));
      end
      tests++;
      if (small_if.p_tick !== (i == 2)) begin
        fails++;
        $display("FAIL first_tick_small clk%0d: got %b expected %b", i, small_if.p_tick, (i == 2));
      end
    end
    // Reach the next tick, then measure one full period.
    n = 0;
    do begin @(negedge clk); n++; end while (!full_if.p_tick && n < 20);
    n = 0;
    do begin @(negedge clk); n++; end while (!full_if.p_tick && n < 20);
    tests++;
    if (n !== 4) begin
      fails++;
      $display("FAIL tick_period: got %0d clk expected 4", n);
    end
  endtask

  task automatic test_hsweep();
    int n, hs_low, vid;
    coord_t ex_x;
    logic ex_vid, ex_hs;
    n = 0;
    while (!(full_if.p_tick && full_if.pixel_x == 10'd799) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 4000) begin
      fails++;
      $display("FAIL hsweep_align: timed out, got x=%0d expected 799", full_if.pixel_x);
      return;
    end
    hs_low = 0;
    vid = 0;
    for (int i = 0; i < 3200; i++) begin
      @(negedge clk);
      ex_x   = coord_t'(i / 4);
      ex_vid = (i / 4) < 640;
      ex_hs  = !((i / 4) >= 656 && (i / 4) <= 751);
      tests++;
      if ({full_if.pixel_x, full_if.pixel_y, full_if.video_on, full_if.hsync} !== {ex_x, 10'd1, ex_vid, ex_hs}) begin
        fails++;
        $display("FAIL hsweep clk%0d: got x=%0d y=%0d vid=%b hs=%b expected x=%0d y=1 vid=%b hs=%b",
                 i, full_if.pixel_x, full_if.pixel_y, full_if.video_on, full_if.hsync, ex_x, ex_vid, ex_hs);
      end
      if (!full_if.hsync) hs_low++;
      if (full_if.video_on) vid++;
    end
    @(negedge clk);
    tests++;
    if (full_if.pixel_x !== 10'd0 || full_if.pixel_y !== 10'd2) begin
      fails++;
      $display("FAIL hsweep_wrap: got x=%0d y=%0d expected 0,2", full_if.pixel_x, full_if.pixel_y);
    end
    tests++;
    if (hs_low !== 384) begin
      fails++;
      $display("FAIL hsync_width: got %0d clk expected 384", hs_low);
    end
    tests++;
    if (vid !== 2560) begin
      fails++;
      $display("FAIL video_on_width: got %0d clk expected 2560", vid);
    end
  endtask

  task automatic test_vsweep();
    bit ok;
    int vs_low, ft_cnt, vis_blank;
    int p;
    coord_t ex_x, ex_y;
    logic ex_hs, ex_vs, ex_vid, ex_ft;
    wait_small(10'd14, 10'd11, 1'b1, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL vsweep_align: timed out at x=%0d y=%0d expected 14,11", small_if.pixel_x, small_if.pixel_y);
      return;
    end
    vs_low = 0;
    ft_cnt = 0;
    vis_blank = 0;
    for (int i = 0; i < 540; i++) begin
      @(negedge clk);
      p      = i / 3;
      ex_x   = coord_t'(p % 15);
      ex_y   = coord_t'(p / 15);
      ex_hs  = !((p % 15) >= 10 && (p % 15) <= 12);
      ex_vs  = !((p / 15) >= 8 && (p / 15) <= 9);
      ex_vid = ((p % 15) < 8) && ((p / 15) < 6);
      ex_ft  = (p == 90) && (i % 3 == 0);
      tests++;
      if ({small_if.pixel_x, small_if.pixel_y, small_if.hsync, small_if.vsync, small_if.video_on, small_if.frame_tick}
          !== {ex_x, ex_y, ex_hs, ex_vs, ex_vid, ex_ft}) begin
        fails++;
        $display("FAIL vsweep clk%0d: got x=%0d y=%0d hs/vs/vid/ft=%b expected x=%0d y=%0d hs/vs/vid/ft=%b",
                 i, small_if.pixel_x, small_if.pixel_y,
                 {small_if.hsync, small_if.vsync, small_if.video_on, small_if.frame_tick},
                 ex_x, ex_y, {ex_hs, ex_vs, ex_vid, ex_ft});
      end
      if (!small_if.vsync) vs_low++;
      if (small_if.frame_tick) ft_cnt++;
      if (small_if.video_on && small_if.pixel_y >= 10'd6) vis_blank++;
    end
    @(negedge clk);
    tests++;
    if (small_if.pixel_x !== 10'd0 || small_if.pixel_y !== 10'd0) begin
      fails++;
      $display("FAIL frame_length: after 540 clk got x=%0d y=%0d expected 0,0", small_if.pixel_x, small_if.pixel_y);
    end
    tests++;
    if (vs_low !== 90) begin
      fails++;
      $display("FAIL vsync_width: got %0d clk expected 90", vs_low);
    end
    tests++;
    if (ft_cnt !== 1 || vis_blank !== 0) begin
      fails++;
      $display("FAIL vsweep_counts: got frame_ticks=%0d video_on_below=%0d expected 1 and 0", ft_cnt, vis_blank);
    end
  endtask

  task automatic test_double_wrap();
    bit ok;
    wait_small(10'd14, 10'd11, 1'b1, ok);
    tests++;
    if (!ok || {small_if.hsync, small_if.vsync, small_if.video_on} !== 3'b110) begin
      fails++;
      $display("FAIL wrap_before: got ok=%b hs/vs/vid=%b expected ok=1 110", ok,
               {small_if.hsync, small_if.vsync, small_if.video_on});
    end
    @(negedge clk);
    tests++;
    if ({small_if.pixel_x, small_if.pixel_y, small_if.hsync, small_if.vsync, small_if.video_on, small_if.frame_tick}
        !== {10'd0, 10'd0, 4'b1110}) begin
      fails++;
      $display("FAIL double_wrap: got x=%0d y=%0d hs/vs/vid/ft=%b expected 0 0 1110",
               small_if.pixel_x, small_if.pixel_y,
               {small_if.hsync, small_if.vsync, small_if.video_on, small_if.frame_tick});
    end
  endtask

  task automatic test_frame_tick();
    int n;
    n = 0;
    while (!small_if.frame_tick && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 1000 || small_if.pixel_x !== 10'd0 || small_if.pixel_y !== 10'd6) begin
      fails++;
      $display("FAIL ft_first: got wait=%0d x=%0d y=%0d expected pulse at 0,6", n, small_if.pixel_x, small_if.pixel_y);
      return;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (small_if.frame_tick !== 1'b0) begin
        fails++;
        $display("FAIL ft_width frame%0d: got %b one clk after pulse expected 0", k, small_if.frame_tick);
      end
      n = 1;
      while (!small_if.frame_tick && n < 2000) begin
        @(negedge clk);
        n++;
      end
      tests++;
      if (n !== 540) begin
        fails++;
        $display("FAIL ft_spacing frame%0d: got %0d clk expected 540", k, n);
      end
      tests++;
      if (small_if.pixel_x !== 10'd0 || small_if.pixel_y !== 10'd6) begin
        fails++;
        $display("FAIL ft_position frame%0d: got x=%0d y=%0d expected 0,6", k, small_if.pixel_x, small_if.pixel_y);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit ft_seen;
    int n;
    wait_small(10'd4, 10'd3, 1'b0, ok);
    tests++;
    if (!ok || small_if.video_on !== 1'b1) begin
      fails++;
      $display("FAIL midreset_pre: got ok=%b video_on=%b expected 1 1", ok, small_if.video_on);
    end
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if ({small_if.p_tick, small_if.hsync, small_if.vsync, small_if.video_on, small_if.frame_tick,
         small_if.pixel_x, small_if.pixel_y} !== {5'b01100, 20'd0}) begin
      fails++;
      $display("FAIL midreset_async: got flags=%b x=%0d y=%0d expected 01100 0 0",
               {small_if.p_tick, small_if.hsync, small_if.vsync, small_if.video_on, small_if.frame_tick},
               small_if.pixel_x, small_if.pixel_y);
    end
    ft_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (small_if.frame_tick) ft_seen = 1'b1;
    end
    tests++;
    if (ft_seen !== 1'b0 || small_if.pixel_x !== 10'd0) begin
      fails++;
      $display("FAIL midreset_hold: got frame_tick_seen=%b x=%0d expected 0 0", ft_seen, small_if.pixel_x);
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      tests++;
      if ({small_if.p_tick, small_if.video_on} !== {(i == 2), (i == 3)} ||
          small_if.pixel_x !== ((i == 3) ? 10'd1 : 10'd0)) begin
        fails++;
        $display("FAIL restart clk%0d: got tick=%b vid=%b x=%0d expected tick=%b vid=%b x=%0d",
                 i, small_if.p_tick, small_if.video_on, small_if.pixel_x, (i == 2), (i == 3), (i == 3));
      end
    end
    n = 3;
    while (!small_if.frame_tick && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== 270 || small_if.pixel_y !== 10'd6) begin
      fails++;
      $display("FAIL restart_frame_tick: got %0d clk y=%0d expected 270 clk y=6", n, small_if.pixel_y);
    end
  endtask

  initial begin
    test_reset();
    test_hsweep();
    test_vsweep();
    test_double_wrap();
    test_frame_tick();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
